// File: rtl/sudoku_grid_checker.sv
// Sudoku grid checker: a row-major loadable grid of SIDE x SIDE cells, then a
// fixed-latency scan of rows, columns and boxes that reports the first rule violation.
module sudoku_grid_checker #(
  parameter int BOX = 3,
  localparam int SIDE = BOX * BOX,
  localparam int DW = $clog2(SIDE + 1),
  localparam int IW = $clog2(SIDE),
  localparam int CW = $clog2(SIDE * SIDE + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid,
  input  logic [DW-1:0] load_value,
  output logic          load_ready,
  input  logic          load_clear,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_class,
  output logic [IW-1:0] err_unit,
  output logic          complete,
  output logic [CW-1:0] loaded_count
);

  localparam int NC = SIDE * SIDE;
  localparam int PW = $clog2(NC);
  localparam logic [DW-1:0] SIDE_V = DW'(SIDE);

  typedef enum logic [2:0] {IDLE, ROWS, COLS, BOXES, DONE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   grid_q [NC];
  logic [DW-1:0]   grid_d [NC];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   unit_q, unit_d, pos_q, pos_d;
  logic [SIDE-1:0] mask_q, mask_d;
  logic            err_q, err_d, empty_q, empty_d, complete_q, complete_d;
  logic [1:0]      cls_q, cls_d;
  logic [IW-1:0]   eunit_q, eunit_d;

  logic            busy_w, accept, is_digit, viol;
  logic [DW-1:0]   cell_val;
  logic [SIDE-1:0] mask_base, digit_bit;
  int              row_i, col_i;

  always_comb begin
    busy_w = (state_q == ROWS) || (state_q == COLS) || (state_q == BOXES);
    accept = (load_valid || load_clear) && !busy_w;

    // Map the (unit, position) scan counters onto a grid cell for the current pass.
    row_i = int'(unit_q);
    col_i = int'(pos_q);
    if (state_q == COLS) begin
      row_i = int'(pos_q);
      col_i = int'(unit_q);
    end else if (state_q == BOXES) begin
      row_i = (int'(unit_q) / BOX) * BOX + int'(pos_q) / BOX;
      col_i = (int'(unit_q) % BOX) * BOX + int'(pos_q) % BOX;
    end
    cell_val  = grid_q[PW'(row_i * SIDE + col_i)];
    mask_base = (pos_q == '0) ? '0 : mask_q;
    digit_bit = {{(SIDE-1){1'b0}}, 1'b1} << (cell_val - DW'(1));
    is_digit  = (cell_val != '0) && (cell_val <= SIDE_V);
    viol      = busy_w && ((cell_val > SIDE_V) || (is_digit && (|(mask_base & digit_bit))));

    state_d    = state_q;
    grid_d     = grid_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    unit_d     = unit_q;
    pos_d      = pos_q;
    mask_d     = mask_q;
    err_d      = err_q;
    cls_d      = cls_q;
    eunit_d    = eunit_q;
    empty_d    = empty_q;
    complete_d = complete_q;

    if (accept) begin
      err_d      = 1'b0;
      cls_d      = 2'd0;
      eunit_d    = '0;
      complete_d = 1'b0;
      if (load_clear) begin
        grid_d = '{default: '0};
        ptr_d  = '0;
        cnt_d  = '0;
      end else begin
        grid_d[ptr_q] = load_value;
        ptr_d = (ptr_q == PW'(NC - 1)) ? '0 : ptr_q + PW'(1);
        if (cnt_q != CW'(NC)) cnt_d = cnt_q + CW'(1);
      end
      if (state_q == DONE) state_d = IDLE;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = ROWS;
          unit_d     = '0;
          pos_d      = '0;
          mask_d     = '0;
          err_d      = 1'b0;
          cls_d      = 2'd0;
          eunit_d    = '0;
          empty_d    = 1'b0;
          complete_d = 1'b0;
        end
      end
      default: begin
        mask_d = is_digit ? (mask_base | digit_bit) : mask_base;
        if (cell_val == '0) empty_d = 1'b1;
        if (viol && !err_q) begin
          err_d   = 1'b1;
          cls_d   = (state_q == ROWS) ? 2'd1 : (state_q == COLS) ? 2'd2 : 2'd3;
          eunit_d = unit_q;
        end
        if (pos_q == IW'(SIDE - 1)) begin
          pos_d = '0;
          if (unit_q == IW'(SIDE - 1)) begin
            unit_d = '0;
            case (state_q)
              ROWS:    state_d = COLS;
              COLS:    state_d = BOXES;
              default: begin
                state_d = DONE;
                // Every cell is visited during the row pass, so empty_q is final here.
                complete_d = !err_d && !empty_q;
              end
            endcase
          end else begin
            unit_d = unit_q + IW'(1);
          end
        end else begin
          pos_d = pos_q + IW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grid_q     <= '{default: '0};
      ptr_q      <= '0;
      cnt_q      <= '0;
      unit_q     <= '0;
      pos_q      <= '0;
      mask_q     <= '0;
      err_q      <= 1'b0;
      cls_q      <= 2'd0;
      eunit_q    <= '0;
      empty_q    <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grid_q     <= grid_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      unit_q     <= unit_d;
      pos_q      <= pos_d;
      mask_q     <= mask_d;
      err_q      <= err_d;
      cls_q      <= cls_d;
      eunit_q    <= eunit_d;
      empty_q    <= empty_d;
      complete_q <= complete_d;
    end
  end

  assign load_ready   = !busy_w;
  assign busy         = busy_w;
  assign done         = (state_q == DONE);
  assign err          = err_q;
  assign err_class    = cls_q;
  assign err_unit     = eunit_q;
  assign complete     = complete_q;
  assign loaded_count = cnt_q;

endmodule

// File: doc/sudoku_grid_checker.md
SUDOKU_GRID_CHECKER -- requirements
Module: sudoku_grid_checker

Interface
REQ-001 Parameter BOX, default 3, box edge length (2..4); derived SIDE = BOX*BOX, cells per grid = SIDE*SIDE.
REQ-002 Derived widths DW = clog2(SIDE+1), IW = clog2(SIDE), CW = clog2(SIDE*SIDE+1); for BOX=3 these are DW=4, IW=4, CW=7.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 load_valid  in  1  cell value offered this cycle.
REQ-006 load_value  in  DW  cell value; 0 = empty, 1..SIDE = digit, >SIDE = illegal.
REQ-007 load_ready  out  1  load/clear accepted this cycle; equals !busy.
REQ-008 load_clear  in  1  zero all cells and rewind write pointer.
REQ-009 start  in  1  request full-grid check.
REQ-010 busy  out  1  check scan in progress.
REQ-011 done  out  1  check finished, results valid.
REQ-012 err  out  1  at least one rule violation found.
REQ-013 err_class  out  2  first violation type: 0 none, 1 row, 2 column, 3 box.
REQ-014 err_unit  out  IW  index of first failing row/column/box (boxes numbered row-major).
REQ-015 complete  out  1  done && !err && no empty cell.
REQ-016 loaded_count  out  CW  cells accepted since reset/clear, saturating at SIDE*SIDE.

Function
REQ-017 Grid storage SHALL be SIDE x SIDE cells of DW bits, written in row-major order via a write pointer.
REQ-018 A load SHALL be accepted when load_valid && load_ready; value goes to the pointed cell, pointer advances next cycle.
REQ-019 Pointer at last cell (SIDE*SIDE-1) SHALL wrap to 0 on accept; later loads overwrite from cell 0.
REQ-020 load_clear with load_ready SHALL zero all cells, pointer and loaded_count in one cycle; it takes priority over a simultaneous load_valid.
REQ-021 Loads and clears while busy SHALL be ignored (load_ready=0), grid unchanged.
REQ-022 Any accepted load or clear SHALL drop done, err, err_class, err_unit, complete to 0.
REQ-023 FSM states: IDLE, ROWS, COLS, BOXES, DONE; start sampled in IDLE or DONE moves to ROWS, clears err/err_class/err_unit/done/complete.
REQ-024 start while busy SHALL be ignored; start and an accepted load in the same cycle: load applies, then scan starts next cycle.
REQ-025 Each scan state SHALL visit exactly one cell per cycle for SIDE*SIDE cycles; unit = SIDE consecutive visits; ROWS->COLS->BOXES->DONE.
REQ-026 Per-unit SIDE-bit seen-mask SHALL clear at each unit start; a nonzero digit whose bit is already set, or any value > SIDE, is a violation.
REQ-027 Empty cells (0) SHALL never cause a violation.
REQ-028 On the first violation only, err=1 and err_class/err_unit latch; later violations do not overwrite; scan continues to the end (fixed latency).
REQ-029 busy SHALL be high exactly 3*SIDE*SIDE cycles; start sampled at edge t gives busy from t+1, done=1 and busy=0 at t+1+3*SIDE*SIDE (t+244 for BOX=3).
REQ-030 err SHALL become visible the cycle after the offending cell is visited.
REQ-031 DONE SHALL hold done, err, err_class, err_unit, complete stable until next start, load, or clear.
REQ-032 complete SHALL be 1 only in DONE with err=0 and no cell equal to 0.

Reset
REQ-033 rst_n low SHALL, asynchronously, force IDLE, pointer=0, loaded_count=0, busy=0, done=0, err=0, err_class=0, err_unit=0, complete=0, seen-mask=0.
REQ-034 Grid cells SHALL reset to 0; reset mid-scan or mid-load aborts with no residual result.

Verification
REQ-035 BOX=3, load valid solved grid (81 loads), start -> busy 243 cycles, done at start+244, err=0, complete=1, loaded_count=81.
REQ-036 Solved grid with row 4 cells 0 and 1 both 7 -> err_class=1, err_unit=4, complete=0.
REQ-037 Cyclic Latin square (row r, col c = ((r+c) mod 9)+1) -> err_class=3, err_unit=0.
REQ-038 Valid grid with cell 0 = 10 -> err_class=1, err_unit=0; valid grid with 5 cells 0 -> err=0, complete=0.
REQ-039 Start, load_valid during busy, start again mid-scan -> grid unchanged, single result at start+244; 82nd load overwrites cell 0, loaded_count stays 81.
REQ-040 Assert rst_n low at scan cycle 100 -> all outputs 0 immediately; BOX=2 solved 4x4 grid -> done at start+49, complete=1.
